// File: rtl/xrst_asm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xrst_asm_pkg
// Description : Shared types and constants for the XRST evidence assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package xrst_asm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        DROP    = 3'd2,
        CHECK   = 3'd3,
        HOLD    = 3'd4
    } asm_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_MAGIC   = 3'd1,
        ERR_SHORT   = 3'd2,
        ERR_LONG    = 3'd3,
        ERR_CSUM    = 3'd4,
        ERR_TIMEOUT = 3'd5
    } asm_err_t;

    localparam int          XRST_PKT_BITS       = 4096;
    localparam logic [15:0] XRST_EVIDENCE_MAGIC = 16'hE51D;

endpackage
`default_nettype wire

// File: rtl/xrst_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : xrst_sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module xrst_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/xrst_evidence_assembler.sv
`default_nettype none
// ============================================================================
// Module      : xrst_evidence_assembler
// Description : Assembles 64-bit stream beats into a validated 4096-bit
//               evidence packet. Define XRST_ASM_TIMEOUT_EN for the
//               inter-beat idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module xrst_evidence_assembler
    import xrst_asm_pkg::*;
#(
    parameter int          WORD_W      = 64,
    parameter int          PKT_WORDS   = 64,
    parameter logic [15:0] MAGIC       = XRST_EVIDENCE_MAGIC,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [WORD_W*PKT_WORDS-1:0] evidence_packet,
    output logic                        packet_valid,
    input  logic                        packet_ready,
    output logic                        err_valid,
    output logic [2:0]                  err_code,
    output logic [31:0]                 pkt_ok_count,
    output logic [31:0]                 pkt_err_count
);

    localparam int             IDX_W    = $clog2(PKT_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    if ((WORD_W * PKT_WORDS != XRST_PKT_BITS) || (TIMEOUT_CYC < 2)) begin : g_cfg_err
        $error("xrst_evidence_assembler: unsupported WORD_W/PKT_WORDS/TIMEOUT_CYC");
    end

    asm_state_t                  state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [WORD_W-1:0]           acc_q;
    logic [WORD_W*PKT_WORDS-1:0] pkt_q;
    logic                        s_ready_q;
    logic                        pv_q;
    logic                        err_valid_q;
    asm_err_t                    err_code_q;

    logic     accept_d;
    logic     magic_ok_d;
    logic     err_det_d;
    asm_err_t err_code_d;
    logic     ok_inc_d;

    assign accept_d   = s_valid && s_ready_q;
    assign magic_ok_d = (s_data[WORD_W-1 -: 16] == MAGIC);
    assign ok_inc_d   = (state_q == HOLD) && pv_q && packet_ready;

`ifdef XRST_ASM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] idle_q;
    logic             timeout_d;

    assign timeout_d = (state_q == COLLECT) && !accept_d &&
                       (idle_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_q != COLLECT) || accept_d) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TMO_W'(1);
        end
    end
`endif

    // Error detection is combinational so the counter and the pulse share one edge.
    always_comb begin
        err_det_d  = 1'b0;
        err_code_d = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept_d && !magic_ok_d) begin
                    err_det_d  = 1'b1;
                    err_code_d = ERR_MAGIC;
                end else if (accept_d && s_last) begin
                    err_det_d  = 1'b1;
                    err_code_d = ERR_SHORT;
                end
            end
            COLLECT: begin
                if (accept_d) begin
                    if ((idx_q != LAST_IDX) && s_last) begin
                        err_det_d  = 1'b1;
                        err_code_d = ERR_SHORT;
                    end else if ((idx_q == LAST_IDX) && !s_last) begin
                        err_det_d  = 1'b1;
                        err_code_d = ERR_LONG;
                    end
                end
`ifdef XRST_ASM_TIMEOUT_EN
                else if (timeout_d) begin
                    err_det_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
`endif
            end
            CHECK: begin
                if (acc_q != pkt_q[(PKT_WORDS-1)*WORD_W +: WORD_W]) begin
                    err_det_d  = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            pkt_q       <= '0;
            s_ready_q   <= 1'b1;
            pv_q        <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            err_valid_q <= err_det_d;
            if (err_det_d) begin
                err_code_q <= err_code_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        if (!magic_ok_d) begin
                            if (!s_last) begin
                                state_q <= DROP;
                            end
                        end else if (!s_last) begin
                            pkt_q[WORD_W-1:0] <= s_data;
                            acc_q             <= s_data;
                            idx_q             <= IDX_W'(1);
                            state_q           <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept_d) begin
                        pkt_q[int'(idx_q)*WORD_W +: WORD_W] <= s_data;
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q != LAST_IDX) begin
                            // The final word is the checksum, so it stays out of acc.
                            acc_q <= acc_q ^ s_data;
                            if (s_last) begin
                                state_q <= IDLE;
                            end
                        end else if (s_last) begin
                            state_q   <= CHECK;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end
`ifdef XRST_ASM_TIMEOUT_EN
                    else if (timeout_d) begin
                        state_q <= IDLE;
                    end
`endif
                end
                DROP: begin
                    if (accept_d && s_last) begin
                        state_q <= IDLE;
                    end
                end
                CHECK: begin
                    if (err_det_d) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b1;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!pv_q) begin
                        pv_q <= 1'b1;
                    end else if (packet_ready) begin
                        pv_q      <= 1'b0;
                        state_q   <= IDLE;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
                    pv_q      <= 1'b0;
                end
            endcase
        end
    end

    xrst_sat_counter #(.WIDTH(32)) u_ok_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ok_inc_d),
        .count_o (pkt_ok_count)
    );

    xrst_sat_counter #(.WIDTH(32)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (err_det_d),
        .count_o (pkt_err_count)
    );

    assign s_ready         = s_ready_q;
    assign evidence_packet = pkt_q;
    assign packet_valid    = pv_q;
    assign err_valid       = err_valid_q;
    assign err_code        = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_xrst_evidence_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_xrst_evidence_assembler
// Description : Directed + randomized bench for xrst_evidence_assembler.
//               Define XRST_ASM_TIMEOUT_EN to cover the idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xrst_evidence_assembler;

    localparam int          N  = 64;
    localparam logic [15:0] MG = 16'hE51D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [4095:0] evidence_packet;
    logic          packet_valid;
    logic          packet_ready = 1'b0;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [31:0]   pkt_ok_count;
    logic [31:0]   pkt_err_count;

    always #5 clk = ~clk;

    xrst_evidence_assembler #(.TIMEOUT_CYC(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .evidence_packet (evidence_packet),
        .packet_valid    (packet_valid),
        .packet_ready    (packet_ready),
        .err_valid       (err_valid),
        .err_code        (err_code),
        .pkt_ok_count    (pkt_ok_count),
        .pkt_err_count   (pkt_err_count)
    );

    int          checks = 0;
    int          errors = 0;
    int          exp_ok = 0;
    int          exp_err = 0;
    int          err_pulses = 0;
    logic [2:0]  last_err = 3'd0;
    int          pv_rises = 0;
    logic        pv_prev = 1'b0;
    logic [63:0] tx_q[$];

    always @(negedge clk) begin
        if (err_valid) begin
            err_pulses++;
            last_err = err_code;
        end
        if (packet_valid && !pv_prev) pv_rises++;
        pv_prev = packet_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic [4095:0] exp);
        int          bad = -1;
        logic [63:0] ow = '0;
        logic [63:0] ew = '0;
        for (int i = 0; i < N; i++) begin
            if (bad < 0 && evidence_packet[i*64 +: 64] !== exp[i*64 +: 64]) begin
                bad = i;
                ow  = evidence_packet[i*64 +: 64];
                ew  = exp[i*64 +: 64];
            end
        end
        checks++;
        assert (evidence_packet === exp) else begin
            errors++;
            $error("FAIL %s word=%0d observed=0x%0h expected=0x%0h", tag, bad, ow, ew);
        end
    endtask

    // Outcome of one packet from its beat list: 0 = delivered, else error code.
    function automatic int model_code();
        logic [63:0] x = '0;
        logic [63:0] w0;
        int          n = tx_q.size();
        w0 = tx_q[0];
        if (w0[63:48] != MG) return 1;
        if (n < N) return 2;
        if (n > N) return 3;
        for (int i = 0; i < N - 1; i++) x ^= tx_q[i];
        if (x != tx_q[N-1]) return 4;
        return 0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic build_good(input bit directed);
        logic [63:0] x = '0;
        logic [63:0] w;
        tx_q.delete();
        for (int i = 0; i < N - 1; i++) begin
            if (directed) w = (i == 0) ? {MG, 48'h1} : 64'(i);
            else begin
                w = rnd64();
                if (i == 0) w[63:48] = MG;
            end
            tx_q.push_back(w);
            x ^= w;
        end
        tx_q.push_back(x);
    endtask

    task automatic set_len(input int len);
        while (tx_q.size() > len) void'(tx_q.pop_back());
        while (tx_q.size() < len) tx_q.push_back(rnd64());
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) chk1("beat_accept_timeout", s_ready, 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_packet(input bit bp);
        int            code;
        int            e0;
        int            p0;
        logic [4095:0] exp_bits;
        code = model_code();
        e0   = err_pulses;
        p0   = pv_rises;
        for (int i = 0; i < tx_q.size(); i++) send(tx_q[i], (i == tx_q.size() - 1));
        if (code == 0) begin
            for (int i = 0; i < N; i++) exp_bits[i*64 +: 64] = tx_q[i];
            @(negedge clk); chk1("pv_not_yet_check", packet_valid, 1'b0);
            @(negedge clk); chk1("pv_not_yet_hold", packet_valid, 1'b0);
            @(negedge clk); chk1("pv_latency", packet_valid, 1'b1);
            chk_pkt("packet_data", exp_bits);
            if (bp) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk1("bp_pv_held", packet_valid, 1'b1);
                    chk1("bp_s_ready_low", s_ready, 1'b0);
                    chk_pkt("bp_data_stable", exp_bits);
                end
            end
            packet_ready = 1'b1;
            @(posedge clk);
            #1;
            packet_ready = 1'b0;
            exp_ok++;
            @(negedge clk);
            chk1("pv_released", packet_valid, 1'b0);
            chk1("s_ready_after_release", s_ready, 1'b1);
        end else begin
            exp_err++;
            repeat (4) @(negedge clk);
            chk("err_pulse_count", 64'(err_pulses - e0), 64'd1);
            chk("err_code", 64'(last_err), 64'(code));
            chk("no_packet_on_error", 64'(pv_rises - p0), 64'd0);
        end
        chk("pkt_ok_count", 64'(pkt_ok_count), 64'(exp_ok));
        chk("pkt_err_count", 64'(pkt_err_count), 64'(exp_err));
    endtask

    task automatic check_reset_state();
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_packet_valid", packet_valid, 1'b0);
        chk1("rst_err_valid", err_valid, 1'b0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_ok_count", 64'(pkt_ok_count), 64'd0);
        chk("rst_err_count", 64'(pkt_err_count), 64'd0);
        chk_pkt("rst_packet", '0);
    endtask

    initial begin
        logic [63:0] w;
        logic [15:0] m;
        int          e0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Directed good packet held under backpressure
        build_good(1'b1);
        run_packet(1'b1);

        // Bad magic followed by 63 more beats
        build_good(1'b1);
        w = tx_q[0];
        w[63:48] = 16'hBEEF;
        tx_q[0] = w;
        run_packet(1'b0);

        // s_last on word 10
        build_good(1'b1);
        set_len(11);
        run_packet(1'b0);

        // 65 beats
        build_good(1'b1);
        set_len(65);
        run_packet(1'b0);

        // Corrupted checksum
        build_good(1'b1);
        tx_q[N-1] = tx_q[N-1] ^ 64'd1;
        run_packet(1'b0);

        for (int k = 0; k < 12; k++) begin
            build_good(1'b0);
            case ($urandom_range(0, 4))
                1: begin
                    m = 16'($urandom);
                    if (m == MG) m = ~m;
                    w = tx_q[0];
                    w[63:48] = m;
                    tx_q[0] = w;
                    set_len($urandom_range(1, 70));
                end
                2: set_len($urandom_range(1, 63));
                3: set_len($urandom_range(65, 70));
                4: tx_q[N-1] = tx_q[N-1] ^ (64'd1 << $urandom_range(0, 63));
                default: ;
            endcase
            run_packet(1'($urandom_range(0, 1)));
        end

`ifdef XRST_ASM_TIMEOUT_EN
        build_good(1'b0);
        e0 = err_pulses;
        for (int i = 0; i < 6; i++) send(tx_q[i], 1'b0);
        repeat (20) @(negedge clk);
        exp_err++;
        chk("timeout_pulse_count", 64'(err_pulses - e0), 64'd1);
        chk("timeout_err_code", 64'(last_err), 64'd5);
        chk("timeout_err_count", 64'(pkt_err_count), 64'(exp_err));
        chk1("timeout_s_ready", s_ready, 1'b1);
        build_good(1'b0);
        run_packet(1'b0);
`endif

        // Reset in the middle of a packet
        build_good(1'b1);
        for (int i = 0; i < 30; i++) send(tx_q[i], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ok  = 0;
        exp_err = 0;
        @(negedge clk);
        check_reset_state();
        build_good(1'b1);
        run_packet(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
